// File: rtl/kds_loader.sv
// Kernel loader for the kernel data shifter: collects one 3x3 kernel per lane
// into a staging buffer, then plays it out column by column over a 3-cycle burst.
module kds_loader #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_LANES      = 12,
    parameter int KERNEL_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic [IO_DATA_WIDTH-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [IO_DATA_WIDTH-1:0] v_1,
    output logic [IO_DATA_WIDTH-1:0] v_2,
    output logic [IO_DATA_WIDTH-1:0] v_3,
    output logic [NB_LANES-1:0]      LE_select,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_W  = $clog2(DEPTH);
    localparam int LANE_W = $clog2(NB_LANES);
    localparam int COL_W  = $clog2(KERNEL_SIZE);

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NB_LANES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_BURST   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]               r_state;
    logic [LANE_W-1:0]        r_lane;
    logic [CNT_W-1:0]         r_word_cnt;
    logic [COL_W-1:0]         r_col;
    logic [IO_DATA_WIDTH-1:0] r_staging [DEPTH];

    logic             w_in_burst;
    logic             w_xfer;
    logic [CNT_W-1:0] w_idx1;
    logic [CNT_W-1:0] w_idx2;
    logic [CNT_W-1:0] w_idx3;

    assign w_in_burst = (r_state == S_BURST);
    assign din_ready  = (r_state == S_COLLECT);
    assign w_xfer     = din_ready && din_valid;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_lane     <= '0;
            r_word_cnt <= '0;
            r_col      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_COLLECT;
                        r_lane     <= '0;
                        r_word_cnt <= '0;
                    end
                end
                S_COLLECT: begin
                    if (din_valid) begin
                        if (r_word_cnt == LAST_WORD) begin
                            r_state    <= S_BURST;
                            r_col      <= '0;
                            r_word_cnt <= '0;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        // Last lane finishes the load instead of wrapping to lane 0.
                        if (r_lane == LAST_LANE) begin
                            r_state <= S_DONE;
                        end else begin
                            r_lane     <= r_lane + 1'b1;
                            r_word_cnt <= '0;
                            r_state    <= S_COLLECT;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_lane  <= '0;
                end
            endcase
        end
    end

    // Staging needs no reset: every entry is rewritten before its lane's burst.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_staging[r_word_cnt] <= din;
        end
    end

    assign w_idx1 = CNT_W'(r_col);
    assign w_idx2 = CNT_W'(r_col) + CNT_W'(KERNEL_SIZE);
    assign w_idx3 = CNT_W'(r_col) + CNT_W'(2 * KERNEL_SIZE);

    always_comb begin
        v_1 = '0;
        v_2 = '0;
        v_3 = '0;
        if (w_in_burst) begin
            v_1 = r_staging[w_idx1];
            v_2 = r_staging[w_idx2];
            v_3 = r_staging[w_idx3];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_LANES; gi++) begin : g_le
            assign LE_select[gi] = w_in_burst && (r_lane == LANE_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_kds_loader.sv
// Directed bench for kds_loader: a per-cycle vector table for one lane plus
// hand-written full-load, backpressure, start-ignore and reset sequences.
module tb_kds_loader;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] v_1, v_2, v_3;
    logic [11:0] LE_select;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    kds_loader #(.IO_DATA_WIDTH(16), .NB_LANES(12), .KERNEL_SIZE(3)) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .v_1       (v_1),
        .v_2       (v_2),
        .v_3       (v_3),
        .LE_select (LE_select),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [15:0] din;
        logic        exp_ready;
        logic [11:0] exp_le;
        logic [15:0] exp_v1;
        logic [15:0] exp_v2;
        logic [15:0] exp_v3;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic s, logic v, logic [15:0] d, logic r, logic [11:0] le,
                                logic [15:0] a, logic [15:0] b, logic [15:0] c,
                                logic bz, logic dn);
        vec_t t;
        t.start = s; t.valid = v; t.din = d; t.exp_ready = r; t.exp_le = le;
        t.exp_v1 = a; t.exp_v2 = b; t.exp_v3 = c; t.exp_busy = bz; t.exp_done = dn;
        return t;
    endfunction

    function automatic logic [63:0] outs();
        return {1'b0, din_ready, LE_select, v_1, v_2, v_3, busy, done};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_in = 1'b0;
    endtask

    // Full load from IDLE; data words count up from 0 on every transfer.
    task automatic run_load(input bit bp, input bit inject);
        int cyc, lane_exp, col, xfers, done_cnt, done_cyc, pat;
        logic [15:0] nxt;
        bit xfer, seen_done, inj3, finished;
        nxt = 0; lane_exp = 0; col = 0; xfers = 0; done_cnt = 0; done_cyc = 0; pat = 0;
        seen_done = 0; inj3 = 0; finished = 0;
        @(negedge clk);
        start = 1'b1; din_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 3000 && !finished; i++) begin
            if (LE_select != 12'h000) begin
                chk("lane_select", LE_select, 12'(1) << lane_exp);
                if (col == 0) chk("xfers_before_burst", xfers, 9);
                chk("burst_v1", v_1, 16'(9 * lane_exp + col));
                chk("burst_v2", v_2, 16'(9 * lane_exp + 3 + col));
                chk("burst_v3", v_3, 16'(9 * lane_exp + 6 + col));
                col++;
                if (col == 3) begin
                    $display("lane %0d loaded at cycle %0d", lane_exp, cyc);
                    col = 0; lane_exp++; xfers = 0;
                end
            end
            if (seen_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", done, 0);
                finished = 1;
            end else if (done) begin
                done_cnt++; done_cyc = cyc; seen_done = 1;
                chk("le_in_done", LE_select, 0);
            end
            if (!finished) begin
                din_valid = bp ? (pat % 3 == 0) : 1'b1;
                pat++;
                din = din_ready ? nxt : 16'hDEAD;
                start = inject && ((din_ready && lane_exp == 3 && !inj3) || done);
                if (start && din_ready) inj3 = 1;
                xfer = din_valid && din_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (xfer) begin nxt++; xfers++; end
                cyc++;
            end
        end
        din_valid = 1'b0;
        chk("load_finished", finished, 1);
        chk("done_count", done_cnt, 1);
        chk("lanes_loaded", lane_exp, 12);
        if (!bp) chk("done_latency", done_cyc, 145);
        if (inject) chk("start_inject_lane3", inj3, 1);
        $display("load bp=%0d inject=%0d done at cycle %0d", bp, inject, done_cyc);
    endtask

    task automatic reset_mid_burst();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b1; din = 16'h0055;
        for (int i = 0; i < 500 && LE_select != 12'h020; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_lane5", LE_select, 12'h020);
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_burst", outs(), 64'h0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("reset_hold", outs(), 64'h0);
        rst_in = 1'b0; start = 1'b0; din_valid = 1'b0;
        @(posedge clk); #1;
        chk("start_with_reset_lost", busy, 0);
        $display("reset mid-burst on lane 5 applied");
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
        do_reset();
        #1;
        chk("reset_state", outs(), 64'h0);

        // Single lane, words 1..9, with a stall + ignored start mid-collect
        // and DEAD offered while not ready.
        vecs[0]  = mk(0, 1, 16'hDEAD, 0, 12'h000, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 16'hDEAD, 1, 12'h000, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 1, 16'd1,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 16'd2,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 16'd3,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[5]  = mk(0, 1, 16'd4,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 0, 16'hDEAD, 1, 12'h000, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 1, 16'd5,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 16'd6,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 16'd7,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 1, 16'd8,    1, 12'h000, 0, 0, 0, 1, 0);
        vecs[11] = mk(0, 1, 16'd9,    0, 12'h001, 1, 4, 7, 1, 0);
        vecs[12] = mk(0, 1, 16'hDEAD, 0, 12'h001, 2, 5, 8, 1, 0);
        vecs[13] = mk(1, 1, 16'hDEAD, 0, 12'h001, 3, 6, 9, 1, 0);
        vecs[14] = mk(0, 0, 16'hDEAD, 1, 12'h000, 0, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 16'hDEAD, 1, 12'h000, 0, 0, 0, 1, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = vecs[i].start; din_valid = vecs[i].valid; din = vecs[i].din;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), outs(),
                {1'b0, vecs[i].exp_ready, vecs[i].exp_le, vecs[i].exp_v1, vecs[i].exp_v2,
                 vecs[i].exp_v3, vecs[i].exp_busy, vecs[i].exp_done});
            $display("vec %0d start=%0b valid=%0b din=0x%04h -> rdy=%0b le=0x%03h v=%0d/%0d/%0d",
                     i, vecs[i].start, vecs[i].valid, vecs[i].din, din_ready, LE_select, v_1, v_2, v_3);
        end
        start = 1'b0; din_valid = 1'b0;

        do_reset();
        run_load(0, 0);
        run_load(1, 1);
        reset_mid_burst();
        run_load(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kds_loader.md
Name: kds_loader

Overview:
- Upstream feeder for the kernel data shifter: streams kernel words from the weight/data path and loads them into the shifter's 12 lanes of 3 recirculating FIFOs.
- Gathers 9 words (one 3x3 kernel) per lane into a staging buffer, then drives a 3-cycle load burst: column words on v_1/v_2/v_3, one-hot LE_select on the target lane.
- Walks lanes 0..NB_LANES-1 per start command, then signals done.

Parameters:
- IO_DATA_WIDTH, 16, word width of din and v_1..v_3.
- NB_LANES, 12, number of shifter lanes, which is also the LE_select width.
- KERNEL_SIZE, 3, burst length and words per row. Fixed at 3 because of the three v outputs; staging depth is KERNEL_SIZE*KERNEL_SIZE = 9.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_in  in  1  synchronous reset, active-high.
- start  in  1  one-cycle command to begin a full load; ignored unless in IDLE.
- din  in  IO_DATA_WIDTH  kernel word, row-major order (r0c0, r0c1, r0c2, r1c0, ... r2c2).
- din_valid  in  1  din holds a word.
- din_ready  out  1  loader accepts din; a transfer happens when din_valid && din_ready.
- v_1  out  IO_DATA_WIDTH  row 0 word of the current burst column.
- v_2  out  IO_DATA_WIDTH  row 1 word of the current burst column.
- v_3  out  IO_DATA_WIDTH  row 2 word of the current burst column.
- LE_select  out  NB_LANES  one-hot lane load enable, high only during BURST.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last lane's burst.

Behaviour:
- All outputs are registered or decoded from registered state; there is no combinational path from din or din_valid to any output.
- Reset (rst_in=1 at the edge) forces the following, whatever the current state:
  - state=IDLE, lane=0, word_cnt=0;
  - din_ready=0, LE_select=0, v_1=v_2=v_3=0, busy=0, done=0;
  - staging contents are don't-care.
  - Reset mid-burst drops LE_select in the next cycle; a partially loaded lane is not completed.
- IDLE:
  - din_ready=0.
  - start=1 -> COLLECT with lane=0, word_cnt=0.
- COLLECT:
  - din_ready=1.
  - Each transfer writes staging[word_cnt]=din and increments word_cnt.
  - din_valid low stalls with no state change.
  - The transfer with word_cnt=8 -> BURST next cycle, col=0.
- BURST (3 cycles, col=0,1,2):
  - din_ready=0.
  - LE_select = 1<<lane.
  - v_1=staging[col], v_2=staging[3+col], v_3=staging[6+col].
  - Latency: first burst cycle is the cycle after the 9th transfer.
  - After col=2: if lane<NB_LANES-1, lane increments and the next cycle is COLLECT with word_cnt=0. Otherwise -> DONE.
- DONE (1 cycle):
  - done=1, LE_select=0.
  - Next state IDLE, lane=0.
- Outside BURST, LE_select=0 and v_1..v_3=0.
- start is ignored in COLLECT, BURST and DONE (no restart, no queueing). start in the same cycle as reset is lost.
- din_valid with din_ready=0 performs no transfer; upstream must hold the word.
- Minimum time per lane is 9 accept cycles plus 3 burst cycles. Full load minimum is 12*12+1 = 145 cycles from the start edge to done.
- word_cnt and col never wrap silently: word_cnt only advances in COLLECT and is cleared on entry; col only advances in BURST.
- lane wrap: after lane NB_LANES-1 the block goes to DONE, never to lane 0 COLLECT.

Test Plan:
- Reset: hold rst_in 2 cycles mid-BURST on lane 5 -> next cycle LE_select=0, v=0, busy=0, din_ready=0. A later start restarts at lane 0.
- Single lane, din_valid always 1, din=1..9:
  - first burst cycle (1 cycle after the 9th accept) has LE_select=12'h001 with v_1/v_2/v_3 = 1/4/7;
  - then 2/5/8;
  - then 3/6/9;
  - then din_ready=1 for lane 1.
- Full load, din continuous, incrementing from 0:
  - lane k burst 0 shows v_1=9k, v_2=9k+3, v_3=9k+6 with LE_select=1<<k;
  - done pulses exactly once, 145 cycles after start;
  - busy falls the cycle after done.
- Backpressure: din_valid toggled 1,0,0,1,... during COLLECT -> exactly 9 transfers counted, burst values unchanged vs. the continuous case, no LE_select before the 9th transfer.
- start asserted in COLLECT on lane 3 and again in DONE -> ignored. A start in IDLE afterwards -> new load from lane 0.
- din_valid=1 in IDLE/BURST/DONE with din=16'hDEAD -> no transfer, staging and burst data unaffected.
